fifo_wr_arbiter: RTL
====================

// Module: fifo_wr_arbiter
// PURPOSE
//  Shares the single write port of one async FIFO between NUM_REQ requesters in the write-clock domain.
//  Round-robin, burst-locked grant; valid/ready handshake per requester; honours FIFO full without data loss.
//  Sits directly in front of the FIFO wen/wdata/wfull interface; the source ID is exported alongside.
// PARAMETERS
//  NUM_REQ     4  number of requesters (>=2)
//  DATA_WIDTH  8  payload width; equals FIFO DATA_WIDTH
//  MAX_BURST   4  max beats per grant before forced rotation (>=1)
// PORTS
//  clk         in   1                    write-domain clock (FIFO wclk)
//  reset       in   1                    asynchronous, active-high reset
//  req_valid   in   NUM_REQ              per-requester beat valid
//  req_last    in   NUM_REQ              marks final beat of a requester's burst
//  req_data    in   NUM_REQ x DATA_WIDTH payload, packed [NUM_REQ-1:0][DATA_WIDTH-1:0]
//  req_ready   out  NUM_REQ              per-requester beat accept
//  fifo_wen    out  1                    FIFO write enable
//  fifo_wdata  out  DATA_WIDTH           FIFO write data
//  fifo_wfull  in   1                    registered FIFO full flag
//  grant_id    out  ID_W                 currently granted requester; valid only while busy=1
//  busy        out  1                    1 in BURST state
// BEHAVIOUR
//  - ID_W = max(1,clog2(NUM_REQ)); CNT_W = max(1,clog2(MAX_BURST)). rr_ptr in [0,NUM_REQ-1].
//  - Reset values: state=IDLE, rr_ptr=0, beat_cnt=0, grant_id=0, busy=0, req_ready=0, fifo_wen=0, fifo_wdata=0.
//  - IDLE: req_ready=0. If any req_valid, pick first set bit scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//    Register grant_id, clear beat_cnt, enter BURST next cycle. Arbitration latency is 1 cycle.
//  - BURST: req_ready[grant_id] = ~fifo_wfull; all other ready bits are 0.
//  - Beat = req_valid[g] & req_ready[g]. On a beat, the same cycle (combinational) drives
//    fifo_wen=1 and fifo_wdata=req_data[g]. fifo_wen is never 1 while fifo_wfull=1.
//  - Release conditions, evaluated in BURST:
//    (a) beat with req_last[g];
//    (b) beat with beat_cnt==MAX_BURST-1;
//    (c) req_valid[g]==0 (requester abandoned).
//    On release: rr_ptr<=g+1 mod NUM_REQ, state<=IDLE. This gives a 1-cycle bubble between grants.
//  - (a)&(b) in the same beat: a single release. Otherwise beat_cnt increments on each beat.
//  - fifo_wfull high: no beats; beat_cnt, grant and state hold indefinitely; no release unless (c).
//  - Reset mid-burst: all state returns to reset values asynchronously. Beats already written stay in the FIFO.
//  - fifo_wdata = 0 when no beat is occurring.
// CONFIGURATION
//  ARB_STATS_EN defined: adds stat_clr (in,1) and stat_beats (out, NUM_REQ x 16).
//    Per-requester beat counter, saturating at 16'hFFFF.
//    Synchronous clear on stat_clr; clear wins over a same-cycle beat. Reset value 0.
//  ARB_STATS_EN undefined: these ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  - Package fifo_arb_pkg: state enum typedef arb_state_t {IDLE, BURST}; function clog2_min1().
//  - Sub-module rr_pick: combinational rotating-priority picker (req vector, rr_ptr -> found, index).
//    Instantiated once.
// TESTING
//  1. Req0 sends 0x11,0x22,0x33, last on 0x33, full=0
//     -> busy 1 cycle after valid; 3 consecutive fifo_wen with those data; then IDLE; rr_ptr=1.
//  2. All 4 valid continuously, no last, MAX_BURST=4
//     -> grant order 0,1,2,3,0; exactly 4 beats each; 1 idle cycle between grants.
//  3. fifo_wfull high 5 cycles after beat 2 of req1
//     -> ready/wen 0 for those cycles; burst resumes; total 4 beats, none lost or duplicated.
//  4. Req2 drops valid after 2 beats while req3 is valid
//     -> release next cycle; req3 granted after 1 idle cycle.
//  5. reset pulse mid-burst of req2
//     -> all outputs reset immediately; then req0..3 valid -> req0 granted first.
//  6. ARB_STATS_EN: 70000 beats from req1
//     -> stat_beats[1]=0xFFFF, others 0; stat_clr -> all 0 next cycle.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and helpers for the FIFO write-port arbiter.
//   arb_state_t  : arbiter FSM state (IDLE, BURST)
//   clog2_min1() : ceil(log2(v)), never less than 1, used for ID and counter widths
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    function automatic int unsigned clog2_min1(input int unsigned v);
        int unsigned w;
        w = $clog2(v);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority picker.
//   req   : request vector
//   ptr   : index that has highest priority this cycle
//   found : at least one request set
//   idx   : first set request scanning ptr, ptr+1, ... modulo NUM_REQ
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               found,
    output logic [ID_W-1:0]    idx
);

    logic [2*NUM_REQ-1:0] rot;
    int unsigned          pos;

    // Duplicating the vector and shifting by ptr puts the highest-priority
    // requester at bit 0, so a plain low-to-high scan gives round-robin order.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        rot   = {req, req} >> ptr;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                pos   = 32'(ptr) + i;
                if (pos >= NUM_REQ) begin
                    pos = pos - NUM_REQ;
                end
                idx = ID_W'(pos);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares one async-FIFO write port between NUM_REQ requesters.
// Round-robin, burst-locked grant with at most MAX_BURST beats per grant.
//   clk, reset           : write-domain clock, async active-high reset
//   req_valid/last/data  : per-requester beat stream
//   req_ready            : per-requester accept (only granted one, only when not full)
//   fifo_wen/wdata       : FIFO write port, combinational from the granted beat
//   fifo_wfull           : registered FIFO full flag
//   grant_id, busy       : current owner (valid while busy) and BURST indicator
// Optional ARB_STATS_EN: adds stat_clr and per-requester saturating stat_beats.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4,
    localparam int unsigned ID_W      = clog2_min1(NUM_REQ),
    localparam int unsigned CNT_W     = clog2_min1(MAX_BURST)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0]                  req_last,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic                                fifo_wen,
    output logic [DATA_WIDTH-1:0]               fifo_wdata,
    input  logic                                fifo_wfull,
`ifdef ARB_STATS_EN
    input  logic                                stat_clr,
    output logic [NUM_REQ-1:0][15:0]            stat_beats,
`endif
    output logic [ID_W-1:0]                     grant_id,
    output logic                                busy
);

    arb_state_t       state, state_nxt;
    logic [ID_W-1:0]  rr_ptr;
    logic [CNT_W-1:0] beat_cnt;
    logic             pick_found;
    logic [ID_W-1:0]  pick_idx;
    logic             beat;
    logic             rel;
    logic [ID_W-1:0]  ptr_after;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_found) state_nxt = BURST;
            BURST:   if (rel)        state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: ready gated by full so a beat can never coincide with wfull
    always_comb begin
        req_ready  = '0;
        beat       = 1'b0;
        fifo_wen   = 1'b0;
        fifo_wdata = '0;
        busy       = (state == BURST);
        if (state == BURST) begin
            req_ready[grant_id] = ~fifo_wfull;
            beat                = req_valid[grant_id] & ~fifo_wfull;
            if (beat) begin
                fifo_wen   = 1'b1;
                fifo_wdata = req_data[grant_id];
            end
        end
    end

    // Abandonment releases even while full; last/max-burst need an actual beat.
    always_comb begin
        rel = 1'b0;
        if (state == BURST) begin
            rel = ~req_valid[grant_id]
                | (beat & (req_last[grant_id] | (beat_cnt == CNT_W'(MAX_BURST - 1))));
        end
        ptr_after = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end

    // Grant, burst counter and round-robin pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr   <= '0;
            beat_cnt <= '0;
            grant_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_idx;
                        beat_cnt <= '0;
                    end
                end
                BURST: begin
                    if (rel) begin
                        rr_ptr <= ptr_after;
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ARB_STATS_EN
    // Per-requester beat counters; clear takes priority over a same-cycle beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_beats <= '0;
        end else if (stat_clr) begin
            stat_beats <= '0;
        end else if (beat && (stat_beats[grant_id] != 16'hFFFF)) begin
            stat_beats[grant_id] <= stat_beats[grant_id] + 16'd1;
        end
    end
`endif

endmodule
